// File: rtl/dmem_write_buffer.sv
// Posted-store write buffer between the CPU MEM stage and a req/ack data RAM.
// Optional store-to-load forwarding is enabled by defining DMEM_STORE_FWD_EN.
module dmem_write_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 16,
    parameter int unsigned DW    = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [AW-1:0]                cpu_addr,
    input  logic [DW-1:0]                cpu_wdata,
    input  logic                         cpu_write,
    input  logic                         cpu_read,
    output logic [DW-1:0]                cpu_rdata,
    output logic                         cpu_stall,
    output logic [AW-1:0]                mem_addr,
    output logic [DW-1:0]                mem_wdata,
    output logic                         mem_write,
    output logic                         mem_read,
    input  logic                         mem_ack,
    input  logic [DW-1:0]                mem_rdata,
    output logic [$clog2(DEPTH+1)-1:0]   wbuf_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StWrite, StRead, StRdone} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   fifo_addr_q [DEPTH];
    logic [DW-1:0]   fifo_data_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    logic full, empty, push, pop, load_req, load_go, load_prio;
    logic fwd_hit;
    logic [DW-1:0] fwd_data;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign push     = cpu_write && !full;
    assign pop      = (state_q == StWrite) && mem_ack;
    assign load_req = cpu_read && !cpu_write;

`ifdef DMEM_STORE_FWD_EN
    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin : p_fwd
        logic [PW-1:0] idx;
        idx      = '0;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PW'(k);
            if ((CW'(k) < count_q) && (fifo_addr_q[idx] == cpu_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = fifo_data_q[idx];
            end
        end
    end
    assign load_go   = load_req && !fwd_hit;
    assign load_prio = load_req && !fwd_hit;
`else
    assign fwd_hit   = 1'b0;
    assign fwd_data  = '0;
    assign load_go   = load_req && empty;
    assign load_prio = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d     = count_q + CW'(push) - CW'(pop);
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (load_go) begin
                    state_d = StRead;
                end else if (!empty) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (mem_ack) begin
                    state_d = ((count_q > CW'(1)) && !load_prio) ? StWrite : StIdle;
                end
            end
            StRead: begin
                if (mem_ack) begin
                    state_d = StRdone;
                    rdata_d = mem_rdata;
                end
            end
            StRdone: begin
                state_d = empty ? StIdle : StWrite;
            end
            default: state_d = StIdle;
        endcase
        // Load a new write request from the (post-pop) head; hold otherwise.
        if ((state_d == StWrite) && ((state_q != StWrite) || pop)) begin
            mem_addr_d  = fifo_addr_q[rd_ptr_d];
            mem_wdata_d = fifo_data_q[rd_ptr_d];
        end else if ((state_d == StRead) && (state_q != StRead)) begin
            mem_addr_d = cpu_addr;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= StIdle;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset && push) begin
            fifo_addr_q[wr_ptr_q] <= cpu_addr;
            fifo_data_q[wr_ptr_q] <= cpu_wdata;
        end
    end

    always_comb begin
        cpu_stall = 1'b0;
        if (reset) begin
            if (cpu_write) begin
                cpu_stall = full;
            end else if (cpu_read) begin
                cpu_stall = !fwd_hit && (state_q != StRdone);
            end
        end
    end

    assign cpu_rdata  = (load_req && fwd_hit) ? fwd_data : rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_write  = (state_q == StWrite);
    assign mem_read   = (state_q == StRead);
    assign wbuf_count = count_q;

endmodule
